// File: rtl/boot_loader_ctrl.sv
// Boot loader sequencer: receives a length/instructions/checksum image on a
// valid/ready stream, writes it into instruction memory and releases the CPU reset.
module boot_loader_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [18:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [18:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  // Stream handshake: a word transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready never depends on in_valid.

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [18:0]       MAX_LEN   = 19'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  IDLE_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);

  localparam logic [1:0] EC_NONE = 2'b00;
  localparam logic [1:0] EC_LEN  = 2'b01;
  localparam logic [1:0] EC_CSUM = 2'b10;
  localparam logic [1:0] EC_TOUT = 2'b11;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        err_code_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   index_q;
  logic [18:0]       csum_q;
  logic [CNT_W-1:0]  idle_q;

  logic accept;
  logic in_xfer;
  logic len_ok;
  logic last_word;
  logic timeout_hit;
  logic csum_match;

  logic cpu_rst_d;
  logic busy_d;
  logic done_d;
  logic err_d;

  assign in_xfer     = (state_q == S_DATA) || (state_q == S_CSUM);
  assign in_ready    = ((state_q == S_LEN) || in_xfer) && !reload && reset;
  assign accept      = in_valid && in_ready;
  assign len_ok      = (in_data != 19'd0) && (in_data <= MAX_LEN);
  assign last_word   = (index_q == (count_q - IDX_ONE));
  assign csum_match  = (in_data == csum_q);
  assign timeout_hit = in_xfer && !accept && (idle_q == IDLE_LAST);
  assign dbg_state   = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reload overrides everything, including an error hold.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code;
    if (reload) begin
      state_d    = S_LEN;
      err_code_d = EC_NONE;
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            if (len_ok) begin
              state_d = S_DATA;
            end else begin
              state_d    = S_ERR;
              err_code_d = EC_LEN;
            end
          end
        end
        S_DATA: begin
          if (accept && last_word) begin
            state_d = S_CSUM;
          end else if (timeout_hit) begin
            state_d    = S_ERR;
            err_code_d = EC_TOUT;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (csum_match) begin
              state_d = S_RUN;
            end else begin
              state_d    = S_ERR;
              err_code_d = EC_CSUM;
            end
          end else if (timeout_hit) begin
            state_d    = S_ERR;
            err_code_d = EC_TOUT;
          end
        end
        S_RUN:   state_d = S_RUN;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_LEN;
      endcase
    end
  end

  // Output decode of the next state; registered below so the outputs line up
  // with the state register.
  always_comb begin
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = (state_d == S_DATA) || (state_d == S_CSUM);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= EC_NONE;
    end else begin
      cpu_rst  <= cpu_rst_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= err_code_d;
    end
  end

  // Image datapath: length, word index, running checksum and idle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      index_q <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
    end else if (reload) begin
      index_q <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
    end else begin
      case (state_q)
        S_LEN: begin
          idle_q <= '0;
          if (accept && len_ok) begin
            count_q <= in_data[ADDR_W:0];
            index_q <= '0;
            csum_q  <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            index_q <= index_q + IDX_ONE;
            csum_q  <= csum_q + in_data;
            idle_q  <= '0;
          end else begin
            idle_q  <= idle_q + IDLE_ONE;
          end
        end
        S_CSUM: begin
          if (accept) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + IDLE_ONE;
          end
        end
        default: idle_q <= '0;
      endcase
    end
  end

  // Instruction memory write port: one registered strobe per DATA word.
  // A write captured just before a reload still goes out the next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= accept && (state_q == S_DATA);
      if (accept && (state_q == S_DATA)) begin
        imem_addr  <= index_q[ADDR_W-1:0];
        imem_wdata <= in_data;
      end
    end
  end

  a_no_ready_when_idle: assert property (
    @(posedge clk) disable iff (!reset)
    ((state_q == S_RUN) || (state_q == S_ERR)) |-> !in_ready
  );

  a_cpu_rst_tracks_run: assert property (
    @(posedge clk) disable iff (!reset)
    cpu_rst == (state_q != S_RUN)
  );

  a_err_code_only_in_err: assert property (
    @(posedge clk) disable iff (!reset)
    (state_q != S_ERR) |-> (err_code == EC_NONE)
  );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized bench for boot_loader_ctrl: image-level reference model feeds
// expected write and outcome queues that a separate monitor drains.
module tb_boot_loader_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1024;
  localparam int WR_W    = ADDR_W + 19;

  logic              clk = 1'b0;
  logic              reset;
  logic [18:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [18:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [2:0]        dbg_state;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WR_W-1:0] exp_wr_q[$];
  logic [2:0]      exp_out_q[$];
  int              wr_cyc_q[$];
  logic [18:0]     img_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every outcome edge is compared against the queues.
  initial begin
    logic prev_done;
    logic prev_err;
    logic [WR_W-1:0] e;
    logic [2:0] o;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (imem_we) begin
          wr_cyc_q.push_back(cyc);
          if (exp_wr_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
          end else begin
            e = exp_wr_q.pop_front();
            chk("imem_write", 32'({imem_addr, imem_wdata}), 32'(e));
          end
        end
        if ((done && !prev_done) || (err && !prev_err)) begin
          if (exp_out_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_outcome: done %0b err %0b code %0b, expected none", done, err, err_code);
          end else begin
            o = exp_out_q.pop_front();
            chk("outcome", 32'({done, err_code}), 32'(o));
            chk("outcome_cpu_rst", 32'(cpu_rst), 32'(!done));
          end
        end
        prev_done = done;
        prev_err  = err;
      end
    end
  end

  // Reference model: works on the whole image held in img_q.
  task automatic push_writes(input int k);
    for (int i = 0; i < k; i++) exp_wr_q.push_back({ADDR_W'(i), img_q[i+1]});
  endtask

  task automatic model(output int n, output logic [2:0] outc);
    int len;
    int total;
    len = int'(img_q[0]);
    if (len < 1 || len > (1 << ADDR_W)) begin
      n    = 1;
      outc = 3'b001;
    end else begin
      total = 0;
      for (int i = 0; i < len; i++) total = (total + int'(img_q[i+1])) % (1 << 19);
      push_writes(len);
      n    = len + 2;
      outc = (int'(img_q[len+1]) == total) ? 3'b100 : 3'b010;
    end
    exp_out_q.push_back(outc);
  endtask

  task automatic make_image(input int len, input bit bad);
    logic [18:0] w;
    logic [18:0] s;
    img_q.delete();
    img_q.push_back(19'(len));
    s = '0;
    for (int i = 0; i < len; i++) begin
      w = 19'($urandom_range(0, 19'h7FFFF));
      img_q.push_back(w);
      s = s + w;
    end
    img_q.push_back(bad ? s + 19'd1 : s);
  endtask

  // Driver tasks: inputs change 1ns after a rising edge.
  task automatic idle(input int n);
    in_valid = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [18:0] d, output bit ok);
    int budget;
    bit acc;
    budget   = 4000;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (budget > 0 && !ok) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
      budget--;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_word: word 0x%0h not accepted within budget, expected acceptance", d);
    end
  endtask

  task automatic wait_outcome();
    int b;
    b = 0;
    while (!(done || err) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (!(done || err)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_outcome: no done/err within budget, expected one");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_image(input int gap_max, input int stall_at, input int stall_len);
    int n;
    logic [2:0] outc;
    bit ok;
    model(n, outc);
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      if (i == stall_at) idle(stall_len);
      else if (gap_max > 0 && i > 0) idle($urandom_range(0, gap_max));
      send_word(img_q[i], ok);
      if (ok && i == 0) chk("busy_after_len", 32'(busy), 32'(n > 1));
    end
    in_valid = 1'b0;
    if (ok) chk("outcome_next_cycle", 32'({done, err, err_code}), 32'({outc[2], !outc[2], outc[1:0]}));
    wait_outcome();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    chk("in_ready_during_reload", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("after_reload", 32'({cpu_rst, done, err, err_code, busy}), 32'(6'b100000));
  endtask

  initial begin
    bit ok;
    bit rdy_seen;
    reset    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b1;
    in_data  = 19'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'(0));
    chk("reset_outputs", 32'({cpu_rst, imem_we, busy, done, err, err_code}), 32'(7'b1000000));
    chk("reset_imem_addr_data", 32'({imem_addr, imem_wdata}), 32'(0));
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Directed image with consecutive writes
    img_q = '{19'd3, 19'h00011, 19'h00022, 19'h00033, 19'h00066};
    wr_cyc_q.delete();
    send_image(0, -1, 0);
    chk("write_count", 32'(wr_cyc_q.size()), 32'(3));
    if (wr_cyc_q.size() == 3) chk("writes_consecutive", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'(2));
    do_reload();

    // Bad checksum, then stream must stay blocked
    img_q = '{19'd3, 19'h00011, 19'h00022, 19'h00033, 19'h00067};
    send_image(0, -1, 0);
    in_valid = 1'b1;
    rdy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rdy_seen |= in_ready;
    end
    chk("no_ready_in_err", 32'(rdy_seen), 32'(0));
    chk("err_code_held", 32'(err_code), 32'(2'b10));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    do_reload();

    // Length boundaries
    img_q = '{19'd0};
    send_image(0, -1, 0);
    do_reload();
    img_q = '{19'd257};
    send_image(0, -1, 0);
    do_reload();
    img_q = '{19'h40001};
    send_image(0, -1, 0);
    do_reload();
    make_image(256, 1'b0);
    send_image(0, -1, 0);
    do_reload();

    // Checksum wrap
    img_q = '{19'd2, 19'h7FFFF, 19'h00002, 19'h00001};
    send_image(0, -1, 0);
    do_reload();

    // Longest tolerated stall, then the shortest fatal one
    make_image(4, 1'b0);
    send_image(0, 3, TIMEOUT - 1);
    do_reload();
    make_image(4, 1'b0);
    push_writes(2);
    exp_out_q.push_back(3'b011);
    for (int i = 0; i < 3; i++) send_word(img_q[i], ok);
    idle(TIMEOUT - 1);
    chk("no_timeout_yet", 32'(err), 32'(0));
    wait_outcome();
    chk("timeout_code", 32'(err_code), 32'(2'b11));
    do_reload();

    // Timeout waiting for the checksum word
    make_image(2, 1'b0);
    push_writes(2);
    exp_out_q.push_back(3'b011);
    for (int i = 0; i < 3; i++) send_word(img_q[i], ok);
    idle(0);
    wait_outcome();
    do_reload();

    // Random images with throttled input
    for (int t = 0; t < 10; t++) begin
      make_image($urandom_range(1, 24), ($urandom_range(0, 3) == 0));
      send_image(6, -1, 0);
      do_reload();
    end

    // reload in RUN with a word offered in the same cycle
    make_image(5, 1'b0);
    send_image(0, -1, 0);
    make_image(3, 1'b0);
    in_valid = 1'b1;
    in_data  = img_q[0];
    do_reload();
    send_image(0, -1, 0);
    chk("run_after_reload", 32'({cpu_rst, done}), 32'(2'b01));

    // reload during DATA aborts; next image restarts at address 0
    in_valid = 1'b0;
    do_reload();
    make_image(10, 1'b0);
    push_writes(4);
    for (int i = 0; i < 5; i++) send_word(img_q[i], ok);
    in_valid = 1'b1;
    in_data  = img_q[5];
    do_reload();
    in_valid = 1'b0;
    make_image(3, 1'b0);
    send_image(2, -1, 0);

    repeat (4) @(posedge clk);
    chk("exp_wr_q_drained", 32'(exp_wr_q.size()), 32'(0));
    chk("exp_out_q_drained", 32'(exp_out_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
